instr_prefetch: RTL and testbench
=================================

# instr_prefetch

Parameterised instruction prefetch queue between the memory space and the instruction decoder of the MSP430 core. It runs its own fetch program counter, issues word reads on the memory address bus, and buffers up to DEPTH returned words. The decoder consumes the words in order with a valid/pop handshake, and a flush redirects fetching on branches, calls, returns and interrupts. It replaces the direct MDB-to-decoder path, so the decoder no longer stalls on every extension word.

## Interface
- SIZE, 16, data/address word width in bits.
- DEPTH, 4, queue capacity in words (power of two, 2..16).
- CW, $clog2(DEPTH+1), width of `count`.

- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- RST_VEC  input  SIZE  boot fetch address, sampled in BOOT.
- hold  input  1  datapath owns the memory bus; fetching pauses.
- fetch_req  output  SIZE=1  read request to memory.
- fetch_addr  output  SIZE  byte address of the requested word (bit 0 always 0).
- fetch_ack  input  1  MDB_out holds the word for fetch_addr this cycle.
- MDB_out  input  SIZE  memory read data.
- flush  input  1  discard the queue and redirect to flush_addr.
- flush_addr  input  SIZE  new fetch address (bit 0 forced to 0).
- pop  input  1  decoder consumes the head word.
- instr_valid  output  1  the head word is valid.
- instr_word  output  SIZE  head word; 0 when empty.
- instr_addr  output  SIZE  byte address of the head word (the decode PC).
- count  output  CW  number of words held.

## Operation
- **State machine:** BOOT, RUN, HOLD.
- **Reset** (rst=0, asynchronous): state BOOT, fetch_pc=0, queue empty, count=0.
  - Outputs: fetch_req=0, fetch_addr=0, instr_valid=0, instr_word=0, instr_addr=0.
- **BOOT:** one cycle; fetch_pc<=RST_VEC&~1; then RUN. fetch_req=0 in BOOT.
- **RUN:** fetch_req = (count<DEPTH) & ~flush; fetch_addr=fetch_pc.
  - On fetch_req&fetch_ack: MDB_out and fetch_pc are written at the tail, and fetch_pc<=fetch_pc+2 (mod 2^SIZE, so 0xFFFE wraps to 0x0000).
  - hold=1 moves to HOLD at the next edge. The same-cycle request is still issued and its ack still accepted.
- **HOLD:** fetch_req=0; the queue can still be popped. When hold=0, return to RUN, with fetch_req asserted the following cycle.
- **Pop:** pop&instr_valid removes the head. count is updated by +ack −pop, so a simultaneous push and pop leaves count unchanged. Pop when empty is ignored.
- **Flush** (any state except BOOT):
  - Queue cleared, count<=0, fetch_pc<=flush_addr&~1.
  - fetch_ack in that cycle is discarded; pop is ignored; state<=RUN even if it was HOLD.
  - If hold is still 1, HOLD is re-entered next cycle.
- **Ignored inputs:** fetch_ack while fetch_req=0 has no effect. Flush during BOOT has no effect.
- **Full queue:** fetch_req is deasserted. It does not depend on a same-cycle pop, so there is no combinational path from pop to fetch_req.
- **Head outputs:** instr_word and instr_addr come from the head entry read pointer. Pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- **Latency:** a fetch acked in cycle N is visible as instr_valid in cycle N+1 (base build).
- **Throughput:** one word per cycle while the memory acks every cycle and the decoder pops every cycle.
- **After flush in cycle N:**
  - fetch_req=0 in N.
  - First request to flush_addr in N+1.
  - First valid word in N+2 (N+1 with bypass).
- **After reset release:** BOOT in cycle 0, first fetch_req in cycle 1.
- **fetch_req/fetch_addr** depend only on registered state, count and flush.

## Configuration
- **PREFETCH_BYPASS_EN defined:**
  - When the queue is empty and fetch_req&fetch_ack, instr_valid=1, instr_word=MDB_out and instr_addr=fetch_addr in the same cycle.
  - A pop in that cycle consumes the word without writing it to the queue, and count stays 0.
- **Not defined:** no combinational path from MDB_out or fetch_ack to the instr_* outputs; the 1-cycle latency applies.

## Test plan
- **Reset/boot:** RST_VEC=0xC000, release rst, ack every cycle, no pop.
  - fetch_addr 0xC000, 0xC002, 0xC004, 0xC006.
  - count reaches 4, then fetch_req=0; instr_word/instr_addr = first word / 0xC000.
- **Streaming:** ack and pop every cycle from 0xF000.
  - count stays 1 (0 with bypass); instr_addr advances by 2 per cycle with no gaps.
- **Flush:** queue holds 3 words, assert flush with flush_addr=0x8001 and fetch_ack=1 in the same cycle.
  - Next cycle count=0, instr_valid=0, fetch_addr=0x8000; the acked word is never visible.
- **Wrap:** flush_addr=0xFFFC, ack 3 words.
  - Addresses 0xFFFC, 0xFFFE, 0x0000; instr_addr values match.
- **Hold:** hold=1 for 3 cycles in RUN.
  - fetch_req=0 from the next cycle until one cycle after hold drops; pops during hold drain the queue correctly.
- **Async reset mid-stream:** pull rst low between clock edges with count=3.
  - Outputs go to reset values immediately; after release, BOOT reloads RST_VEC.

Source files
------------

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: runs its own fetch PC, buffers up to DEPTH words for the decoder.
// Optional macro PREFETCH_BYPASS_EN forwards an acked word straight to the decoder when the queue is empty.
module instr_prefetch #(
  parameter int SIZE  = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] RST_VEC,
  input  logic            hold,
  output logic            fetch_req,
  output logic [SIZE-1:0] fetch_addr,
  input  logic            fetch_ack,
  input  logic [SIZE-1:0] MDB_out,
  input  logic            flush,
  input  logic [SIZE-1:0] flush_addr,
  input  logic            pop,
  output logic            instr_valid,
  output logic [SIZE-1:0] instr_word,
  output logic [SIZE-1:0] instr_addr,
  output logic [CW-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SIZE-1:0] ALIGN_MASK = {{(SIZE-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0]   FULL_CNT   = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [SIZE-1:0] word_mem [DEPTH];
  logic [SIZE-1:0] addr_mem [DEPTH];

  logic queue_empty;
  logic queue_full;
  logic push;
  logic byp_hit;
  logic byp_pop;
  logic q_pop;
  logic wr_en;

  assign queue_empty = (count_q == '0);
  assign queue_full  = (count_q == FULL_CNT);

  // Request depends only on registered state and flush, never on a same-cycle pop.
  assign fetch_req  = (state_q == S_RUN) && !queue_full && !flush;
  assign fetch_addr = fetch_pc_q;
  assign push       = fetch_req & fetch_ack;
  assign q_pop      = pop & ~flush & ~queue_empty;

`ifdef PREFETCH_BYPASS_EN
  assign byp_hit = push & queue_empty;
`else
  assign byp_hit = 1'b0;
`endif

  // A bypassed word consumed in the same cycle never lands in the queue.
  assign byp_pop = byp_hit & pop;
  assign wr_en   = push & ~byp_pop;
  assign count   = count_q;

`ifdef PREFETCH_BYPASS_EN
  assign instr_valid = ~queue_empty | byp_hit;
  assign instr_word  = !queue_empty ? word_mem[rd_ptr_q] : (byp_hit ? MDB_out    : '0);
  assign instr_addr  = !queue_empty ? addr_mem[rd_ptr_q] : (byp_hit ? fetch_pc_q : '0);
`else
  assign instr_valid = ~queue_empty;
  assign instr_word  = !queue_empty ? word_mem[rd_ptr_q] : '0;
  assign instr_addr  = !queue_empty ? addr_mem[rd_ptr_q] : '0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    case (state_q)
      S_BOOT: begin
        fetch_pc_d = RST_VEC & ALIGN_MASK;
        state_d    = S_RUN;
      end
      S_RUN, S_HOLD: begin
        if (flush) begin
          fetch_pc_d = flush_addr & ALIGN_MASK;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          state_d    = S_RUN;
        end else begin
          if (push) begin
            fetch_pc_d = fetch_pc_q + SIZE'(2);
          end
          if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
          if (q_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
          count_d = count_q + CW'(wr_en) - CW'(q_pop);
          if (state_q == S_RUN && hold) begin
            state_d = S_HOLD;
          end else if (state_q == S_HOLD && !hold) begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      word_mem[wr_ptr_q] <= MDB_out;
      addr_mem[wr_ptr_q] <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch (default build): directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_instr_prefetch;

  localparam int SIZE  = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic            clk;
  logic            rst;
  logic [SIZE-1:0] RST_VEC;
  logic            hold;
  logic            fetch_req;
  logic [SIZE-1:0] fetch_addr;
  logic            fetch_ack;
  logic [SIZE-1:0] MDB_out;
  logic            flush;
  logic [SIZE-1:0] flush_addr;
  logic            pop;
  logic            instr_valid;
  logic [SIZE-1:0] instr_word;
  logic [SIZE-1:0] instr_addr;
  logic [CW-1:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  instr_prefetch #(.SIZE(SIZE), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .RST_VEC(RST_VEC), .hold(hold),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .MDB_out(MDB_out), .flush(flush), .flush_addr(flush_addr), .pop(pop),
    .instr_valid(instr_valid), .instr_word(instr_word), .instr_addr(instr_addr),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  assign MDB_out = mem_f(fetch_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 0=boot 1=run 2=hold, fetch PC, queue of buffered word addresses.
  int          m_state;
  logic [15:0] m_pc;
  logic [15:0] m_q[$];

  always @(negedge clk) begin
    logic        exp_req;
    logic [15:0] head_a;
    if (!rst) begin
      m_state = 0;
      m_pc    = 16'h0000;
      m_q.delete();
      chk("rst_req",   32'(fetch_req),   32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_count", 32'(count),       32'd0);
      chk("rst_addr",  32'(fetch_addr),  32'd0);
    end else begin
      exp_req = (m_state == 1) && (m_q.size() < DEPTH) && !flush;
      chk("fetch_req",  32'(fetch_req),  32'(exp_req));
      chk("fetch_addr", 32'(fetch_addr), 32'(m_pc));
      chk("count",      32'(count),      32'(m_q.size()));
      chk("valid",      32'(instr_valid), 32'(m_q.size() > 0));
      head_a = (m_q.size() > 0) ? m_q[0] : 16'h0000;
      chk("instr_addr", 32'(instr_addr), 32'(head_a));
      chk("instr_word", 32'(instr_word), (m_q.size() > 0) ? 32'(mem_f(head_a)) : 32'd0);
      $display("cyc t=%0t st=%0d req=%b addr=%h ack=%b pop=%b cnt=%0d head=%h",
               $time, m_state, exp_req, m_pc, fetch_ack, pop, m_q.size(), head_a);
      if (m_state == 0) begin
        m_pc    = RST_VEC & 16'hFFFE;
        m_state = 1;
      end else if (flush) begin
        m_q.delete();
        m_pc    = flush_addr & 16'hFFFE;
        m_state = 1;
      end else begin
        if (pop && m_q.size() > 0) void'(m_q.pop_front());
        if (exp_req && fetch_ack) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 16'd2;
        end
        if (m_state == 1 && hold) m_state = 2;
        else if (m_state == 2 && !hold) m_state = 1;
      end
    end
  end

  task automatic drive(input logic a, input logic p, input logic h, input logic f,
                       input logic [15:0] fa, input int n);
    @(posedge clk);
    #1;
    fetch_ack  = a;
    pop        = p;
    hold       = h;
    flush      = f;
    flush_addr = fa;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; RST_VEC = 16'hC000; hold = 1'b0; fetch_ack = 1'b0;
    flush = 1'b0; flush_addr = 16'h0000; pop = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    drive(1, 0, 0, 0, 16'h0000, 8);        // boot + fill to full
    drive(1, 0, 0, 1, 16'hF000, 1);        // flush with ack discarded
    drive(1, 1, 0, 0, 16'h0000, 10);       // streaming
    drive(0, 0, 0, 1, 16'h1000, 1);
    drive(1, 0, 0, 0, 16'h0000, 3);        // three words buffered
    drive(1, 0, 0, 1, 16'h8001, 1);        // flush, acked word dropped
    drive(0, 0, 0, 0, 16'h0000, 3);
    drive(0, 0, 0, 1, 16'hFFFC, 1);        // address wrap
    drive(1, 0, 0, 0, 16'h0000, 3);
    drive(0, 1, 0, 0, 16'h0000, 4);
    drive(1, 0, 0, 0, 16'h0000, 2);        // hold scenario
    drive(1, 1, 1, 0, 16'h0000, 3);
    drive(1, 0, 0, 0, 16'h0000, 3);
    drive(1, 0, 1, 1, 16'h3000, 1);        // flush while hold stays high
    drive(1, 0, 1, 0, 16'h0000, 2);
    drive(0, 1, 0, 0, 16'h0000, 2);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3) != 0), $urandom_range(1), ($urandom_range(3) == 0),
            ($urandom_range(15) == 0), 16'($urandom), 1);
    end

    drive(0, 0, 0, 1, 16'h2000, 1);        // async reset with count=3
    drive(1, 0, 0, 0, 16'h0000, 3);
    drive(0, 0, 0, 0, 16'h0000, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    RST_VEC = 16'hE001;
    #1;
    chk("async_req",   32'(fetch_req),   32'd0);
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_count", 32'(count),       32'd0);
    chk("async_word",  32'(instr_word),  32'd0);
    chk("async_iaddr", 32'(instr_addr),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    drive(1, 0, 0, 0, 16'h0000, 6);
    drive(0, 1, 0, 0, 16'h0000, 5);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
